// File: rtl/cir_q_ctrl.sv
// cir_q_ctrl: pointer/occupancy controller for a circular-queue data array.
// Allocates entries in order at the tail, tracks per-entry valid/done bits,
// retires done entries in order from the head, and drives the array's
// write/read/commit ports.
//
// Handshakes: a transfer fires on a cycle where valid and ready are both high
// at the rising edge; ready never depends on valid. Enqueue: enq_valid/enq_ready.
// Commit: commit_valid/commit_ready (and no flush). Valid is held by the
// producer until the transfer fires.
module cir_q_ctrl #(
    parameter int s_index = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               enq_valid,
    output logic               enq_ready,
    output logic [s_index-1:0] enq_tag,
    input  logic               done_valid,
    input  logic [s_index-1:0] done_index,
    output logic               commit_valid,
    input  logic               commit_ready,
    output logic [s_index-1:0] commit_tag,
    input  logic               rd_req,
    input  logic [s_index-1:0] rd_index,
    output logic               rd_resp_valid,
    output logic               array_write,
    output logic [s_index-1:0] array_windex,
    output logic               array_read,
    output logic [s_index-1:0] array_rindex,
    output logic [s_index-1:0] array_commit_index,
    output logic [s_index:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 2 ** s_index;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [s_index:0]   head;
    logic [s_index:0]   tail;
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   done_q;
    logic               rd_resp_q;

    logic [s_index-1:0] head_idx;
    logic [s_index-1:0] tail_idx;
    logic               enq_fire;
    logic               commit_fire;
    logic               done_fire;

    assign head_idx = head[s_index-1:0];
    assign tail_idx = tail[s_index-1:0];

    // Occupancy flags, handshake decodes and array port drive.
    always_comb begin
        empty              = (head == tail);
        full               = (head_idx == tail_idx) && (head[s_index] != tail[s_index]);
        count              = tail - head;
        // Ready uses the current-cycle full flag only: a same-cycle commit
        // does not open a slot for a same-cycle enqueue.
        enq_ready          = !full && !flush;
        enq_fire           = enq_valid && enq_ready;
        enq_tag            = tail_idx;
        array_write        = enq_fire;
        array_windex       = tail_idx;
        commit_valid       = !empty && done_q[head_idx];
        commit_fire        = commit_valid && commit_ready && !flush;
        commit_tag         = head_idx;
        array_commit_index = head_idx;
        // Completion of an entry that was never allocated is dropped.
        done_fire          = done_valid && valid_q[done_index] && !flush;
        array_read         = rd_req;
        array_rindex       = rd_index;
        rd_resp_valid      = rd_resp_q;
    end

    // Pointer and per-entry state update; reset beats flush beats normal work.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (done_fire) begin
                done_q[done_index] <= 1'b1;
            end
            // Commit clears after the done set so a redundant done on the
            // retiring head cannot resurrect it.
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head              <= head + 1'b1;
            end
            // Tail slot is never the head slot here (not full / not empty),
            // and a done on the tail slot was already dropped as invalid.
            if (enq_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail              <= tail + 1'b1;
            end
        end
    end

    // Read response tracks the registered array read one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_resp_q <= 1'b0;
        end else begin
            rd_resp_q <= rd_req;
        end
    end

endmodule

// File: tb/tb_cir_q_ctrl.sv
// tb_cir_q_ctrl: directed scenarios plus random traffic against a queue-level
// reference model (list of allocated tags with their done flags).
module tb_cir_q_ctrl;

  localparam int SI    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [SI-1:0] enq_tag;
  logic          done_valid;
  logic [SI-1:0] done_index;
  logic          commit_valid;
  logic          commit_ready;
  logic [SI-1:0] commit_tag;
  logic          rd_req;
  logic [SI-1:0] rd_index;
  logic          rd_resp_valid;
  logic          array_write;
  logic [SI-1:0] array_windex;
  logic          array_read;
  logic [SI-1:0] array_rindex;
  logic [SI-1:0] array_commit_index;
  logic [SI:0]   count;
  logic          full;
  logic          empty;

  cir_q_ctrl #(.s_index(SI)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .enq_valid          (enq_valid),
    .enq_ready          (enq_ready),
    .enq_tag            (enq_tag),
    .done_valid         (done_valid),
    .done_index         (done_index),
    .commit_valid       (commit_valid),
    .commit_ready       (commit_ready),
    .commit_tag         (commit_tag),
    .rd_req             (rd_req),
    .rd_index           (rd_index),
    .rd_resp_valid      (rd_resp_valid),
    .array_write        (array_write),
    .array_windex       (array_windex),
    .array_read         (array_read),
    .array_rindex       (array_rindex),
    .array_commit_index (array_commit_index),
    .count              (count),
    .full               (full),
    .empty              (empty)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  int q_tag[$];   // allocated tags, oldest first
  bit q_done[$];  // done flag per allocated tag
  int next_tag = 0;
  bit prev_rd  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs at negedge, advance the model at posedge.
  task automatic step();
    int sz;
    bit e_full, e_empty, e_rdy, e_wr, e_cv, e_cfire;
    int e_ctag;
    @(negedge clk);
    sz      = q_tag.size();
    e_full  = (sz == DEPTH);
    e_empty = (sz == 0);
    e_rdy   = !e_full && !flush;
    e_wr    = enq_valid && e_rdy;
    e_cv    = !e_empty && q_done[0];
    e_ctag  = e_empty ? next_tag : q_tag[0];
    e_cfire = e_cv && commit_ready && !flush;
    check("enq_ready", enq_ready, e_rdy);
    check("enq_tag", enq_tag, next_tag);
    check("array_write", array_write, e_wr);
    if (e_wr) check("array_windex", array_windex, next_tag);
    check("commit_valid", commit_valid, e_cv);
    check("commit_tag", commit_tag, e_ctag);
    check("array_commit_index", array_commit_index, e_ctag);
    check("count", count, sz);
    check("full", full, e_full);
    check("empty", empty, e_empty);
    check("array_read", array_read, rd_req);
    if (rd_req) check("array_rindex", array_rindex, rd_index);
    check("rd_resp_valid", rd_resp_valid, prev_rd);
    @(posedge clk);
    if (!rst) begin
      q_tag.delete();
      q_done.delete();
      next_tag = 0;
      prev_rd  = 1'b0;
    end else begin
      prev_rd = rd_req;
      if (flush) begin
        q_tag.delete();
        q_done.delete();
        next_tag = 0;
      end else begin
        if (done_valid)
          for (int i = 0; i < q_tag.size(); i++)
            if (q_tag[i] == int'(done_index)) q_done[i] = 1'b1;
        if (e_cfire) begin
          void'(q_tag.pop_front());
          void'(q_done.pop_front());
        end
        if (e_wr) begin
          q_tag.push_back(next_tag);
          q_done.push_back(1'b0);
          next_tag = (next_tag + 1) % DEPTH;
        end
      end
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit ev, input bit dv, input int di, input bit cr,
                       input bit fl, input bit rq, input int ri);
    enq_valid    = ev;
    done_valid   = dv;
    done_index   = SI'(di);
    commit_ready = cr;
    flush        = fl;
    rd_req       = rq;
    rd_index     = SI'(ri);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    enq_valid = 0; done_valid = 0; done_index = '0; commit_ready = 0;
    flush = 0; rd_req = 0; rd_index = '0;
    @(posedge clk);
    #1;
    // Reset held two cycles, then released.
    idle(2);
    rst = 1'b1;
    idle(1);

    // Fill 32 plus one extra request while full.
    for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, 0, 0, 0, 0, 0);
    // Mark every entry done, then commit 4 and refill 4 (wrap to tags 0..3).
    for (int i = 0; i < DEPTH; i++) drive(0, 1, i, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0);
    // Mark the wrapped entries done, drain to 16, then concurrent enq+commit.
    for (int i = 0; i < 4; i++) drive(0, 1, i, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 0, 0, 0);
    // Drain to 10, then flush with enqueue and commit both requested.
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 12, 1, 1, 0, 0);
    idle(1);

    // Out-of-order done, in-order commit.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0);

    // Read path and a done on an unallocated entry.
    drive(0, 0, 0, 0, 0, 1, 7);
    drive(1, 1, 20, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int di;
      bit fl;
      if ($urandom_range(0, 1) == 1 && q_tag.size() > 0)
        di = q_tag[$urandom_range(0, q_tag.size() - 1)];
      else
        di = $urandom_range(0, DEPTH - 1);
      fl  = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, di,
            $urandom_range(0, 2) != 0, fl, $urandom_range(0, 1) == 1,
            $urandom_range(0, DEPTH - 1));
    end
    rst = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cir_q_ctrl.md
Name: cir_q_ctrl

Overview:
- Pointer and occupancy controller for the circular-queue data array: allocates entries in order, tracks per-entry valid/done, and retires them in order.
- Drives the array's write/read/commit index and enable inputs.
- Sits between the dispatch stage (allocation), the execution units (completion marking) and the commit stage (in-order retire), in the ROB/LSQ style.

Parameters:
s_index, 5, log2 of queue depth; DEPTH = 2**s_index entries.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 at posedge = reset)
flush  input  1  discard all entries
enq_valid  input  1  allocation request
enq_ready  output  1  allocation accepted this cycle if enq_valid
enq_tag  output  s_index  index allocated on enqueue (= tail)
done_valid  input  1  mark an entry complete
done_index  input  s_index  entry to mark complete
commit_valid  output  1  head entry valid and done
commit_ready  input  1  commit stage accepts head entry
commit_tag  output  s_index  head index
rd_req  input  1  random read of an entry
rd_index  input  s_index  entry to read
rd_resp_valid  output  1  array dataout valid (1 cycle after rd_req)
array_write  output  1  array write enable
array_windex  output  s_index  array write index
array_read  output  1  array read enable
array_rindex  output  s_index  array read index
array_commit_index  output  s_index  array commit index (= head)
count  output  s_index+1  occupied entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- State:
  - head and tail pointers, s_index+1 bits each; the MSB is the wrap bit.
  - valid[DEPTH] and done[DEPTH] bit vectors.
  - rd_resp_valid register.
- Flags:
  - empty when head == tail (all bits).
  - full when index bits are equal and wrap bits differ.
  - count = tail - head, modulo 2**(s_index+1).
- Reset (rst==0 at posedge):
  - head = tail = 0; all valid/done = 0; rd_resp_valid = 0.
  - Resulting outputs: enq_ready 1, empty 1, full 0, count 0, commit_valid 0, enq_tag 0, commit_tag 0.
  - Reset overrides flush and all requests in that cycle.
  - This block does not reset the data array.
- Enqueue:
  - enq_ready = !full && !flush.
  - Fire = enq_valid && enq_ready.
  - On fire, combinationally: array_write = 1, array_windex = tail[s_index-1:0], enq_tag = same.
  - Next edge: valid[tail] <= 1, done[tail] <= 0, tail <= tail + 1.
  - Zero latency: the payload is written in the same cycle.
- Full boundary: enq_ready is computed from the current-cycle full flag. A commit in the same cycle does not free a slot for a same-cycle enqueue.
- Completion:
  - done_valid with valid[done_index] == 1 sets done[done_index] on the next edge.
  - done_valid on an invalid entry is ignored (no state change).
  - done_valid on an already-done entry is idempotent.
- Commit:
  - commit_valid = !empty && done[head].
  - commit_tag = array_commit_index = head[s_index-1:0], so the array's commit data is valid combinationally in the same cycle.
  - Fire = commit_valid && commit_ready && !flush.
  - Next edge: valid[head] <= 0, done[head] <= 0, head <= head + 1.
  - Empty boundary: no same-cycle bypass; an entry enqueued in cycle N commits no earlier than cycle N+2 (done no earlier than N+1).
- Simultaneous enqueue and commit (not full, not empty): both fire and count is unchanged. The head and tail indices differ, so valid/done updates do not conflict.
- Simultaneous done and commit on different entries: both apply.
- Read path:
  - array_read = rd_req; array_rindex = rd_index.
  - rd_resp_valid <= rd_req, giving one-cycle latency to match the registered array read.
  - Reads never alter queue state and are allowed during flush.
- Flush (rst==1, flush==1):
  - Next edge: head = tail = 0; all valid/done = 0.
  - enq_ready = 0 and array_write = 0 in the flush cycle.
  - Commit and done are suppressed in the flush cycle.
  - The queue accepts enqueue again the cycle after the flush.
- Wrap-around: pointers increment modulo 2**(s_index+1); the index bits wrap from DEPTH-1 to 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> empty=1, full=0, count=0, enq_ready=1, commit_valid=0, enq_tag=0.
- Fill: 32 back-to-back enqueues (s_index=5) -> enq_tags 0..31, array_write pulses with array_windex 0..31, then full=1, count=32, enq_ready=0. A 33rd enq_valid leaves tail unchanged.
- Out-of-order done, in-order commit:
  - Enqueue tags 0,1,2; done 2 then 1 with commit_ready=1 -> commit_valid stays 0.
  - Done 0 -> commits of 0,1,2 on three consecutive cycles; empty=1 afterwards.
- Wrap:
  - Fill to 32, mark all done, commit 4 -> count=28.
  - Enqueue 4 -> enq_tags 0..3, full=1.
  - Concurrent enqueue+commit at count=16 -> count stays 16.
- Flush: flush at count=10 with enq_valid=1 and commit_valid=1 in the same cycle -> no array_write, no commit. Next cycle count=0, empty=1, enq_tag=0.
- Read and illegal done:
  - rd_req with rd_index=7 -> array_read=1, array_rindex=7; rd_resp_valid=1 exactly one cycle later.
  - done_valid on an invalid index 20 -> done vector unchanged.
